// File: rtl/sm_pkg.sv
// ============================================================================
// Module   : sm_pkg
// Purpose  : Shared state encoding and configuration helpers for sm_multiplier_core.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } sm_state_t;

  function automatic int unsigned sm_iterations(input int unsigned width,
                                                input int unsigned step);
    return width / step;
  endfunction

  // Legal configurations: at least 2-bit operands, radix-2/4/16 digits, whole digits only.
  function automatic bit sm_cfg_legal(input int unsigned width,
                                      input int unsigned step);
    return (width >= 2) && ((step == 1) || (step == 2) || (step == 4)) &&
           ((width % step) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_partial_adder.sv
// ============================================================================
// Module   : sm_partial_adder
// Purpose  : Combinational acc_hi + |A| * digit for one multiplier iteration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sm_partial_adder
  import sm_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH+STEP-1:0] i_acc_hi,
  input  logic [WIDTH-1:0]      i_mag_a,
  input  logic [STEP-1:0]       i_digit,
  output logic [WIDTH+STEP-1:0] o_sum
);

  logic [WIDTH+STEP-1:0] w_a_ext;
  logic [WIDTH+STEP-1:0] w_digit_ext;
  logic [WIDTH+STEP-1:0] w_partial;

  // |A| * digit never exceeds WIDTH+STEP bits, and neither does the sum,
  // because acc_hi only ever holds a WIDTH-bit value at the start of an iteration.
  assign w_a_ext     = {{STEP{1'b0}}, i_mag_a};
  assign w_digit_ext = {{WIDTH{1'b0}}, i_digit};
  assign w_partial   = w_a_ext * w_digit_ext;
  assign o_sum       = i_acc_hi + w_partial;

endmodule

`default_nettype wire

// File: rtl/sm_multiplier_core.sv
// ============================================================================
// Module   : sm_multiplier_core
// Purpose  : Start/busy/done sequential signed/unsigned WIDTH x WIDTH multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sm_multiplier_core
  import sm_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic               clock,
  input  logic               reset_in,
  input  logic               start_in,
  input  logic               signed_in,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [2*WIDTH-1:0] product_out,
  output logic               overflow_out
);

  localparam int unsigned c_iters  = sm_iterations(WIDTH, STEP);
  localparam int          c_cnt_w  = $clog2(c_iters + 1);
  localparam bit          c_cfg_ok = sm_cfg_legal(WIDTH, STEP);

  generate
    if (!c_cfg_ok) begin : g_cfg_check
      $fatal(1, "sm_multiplier_core: illegal WIDTH/STEP combination");
    end
  endgenerate

  sm_state_t              r_state;
  sm_state_t              w_next_state;
  logic [WIDTH-1:0]       r_mag_a;
  logic [WIDTH+STEP-1:0]  r_acc_hi;
  logic [WIDTH-1:0]       r_acc_lo;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_neg;
  logic                   r_signed;
  logic [2*WIDTH-1:0]     r_product;
  logic                   r_overflow;
  logic                   r_done;

  logic                   w_neg_a;
  logic                   w_neg_b;
  logic [WIDTH-1:0]       w_abs_a;
  logic [WIDTH-1:0]       w_abs_b;
  logic [WIDTH+STEP-1:0]  w_sum;
  logic [2*WIDTH+STEP-1:0] w_shifted;
  logic [2*WIDTH-1:0]     w_mag;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH:0]         w_sign_field;
  logic                   w_ovf;
  logic                   w_last_iter;

  // Operand conditioning: the most negative value maps onto its unsigned magnitude.
  assign w_neg_a = signed_in & multiplicand_in[WIDTH-1];
  assign w_neg_b = signed_in & multiplier_in[WIDTH-1];
  assign w_abs_a = w_neg_a ? -multiplicand_in : multiplicand_in;
  assign w_abs_b = w_neg_b ? -multiplier_in   : multiplier_in;

  sm_partial_adder #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_partial_adder (
    .i_acc_hi (r_acc_hi),
    .i_mag_a  (r_mag_a),
    .i_digit  (r_acc_lo[STEP-1:0]),
    .o_sum    (w_sum)
  );

  assign w_shifted   = {w_sum, r_acc_lo} >> STEP;
  assign w_last_iter = (r_cnt == c_cnt_w'(1));

  assign w_mag        = {r_acc_hi[WIDTH-1:0], r_acc_lo};
  assign w_prod       = r_neg ? -w_mag : w_mag;
  assign w_sign_field = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_ovf        = r_signed ? !((&w_sign_field) || (~|w_sign_field))
                                 : (|w_prod[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start_in) w_next_state = RUN;
      RUN:     if (w_last_iter) w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      r_mag_a    <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_signed   <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_mag_a  <= w_abs_a;
            r_acc_hi <= '0;
            r_acc_lo <= w_abs_b;
            r_cnt    <= c_cnt_w'(c_iters);
            r_neg    <= w_neg_a ^ w_neg_b;
            r_signed <= signed_in;
          end
        end
        RUN: begin
          r_acc_hi <= w_shifted[2*WIDTH+STEP-1:WIDTH];
          r_acc_lo <= w_shifted[WIDTH-1:0];
          r_cnt    <= r_cnt - c_cnt_w'(1);
        end
        FIX: begin
          r_product  <= w_prod;
          r_overflow <= w_ovf;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_out     = (r_state != IDLE);
  assign done_out     = r_done;
  assign product_out  = r_product;
  assign overflow_out = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sm_multiplier_core.sv
// ============================================================================
// Module   : tb_sm_multiplier_core
// Purpose  : Self-checking bench for sm_multiplier_core at STEP = 1, 2 and 4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sm_multiplier_core;

  logic        clock = 1'b0;
  logic        reset_in;
  logic        start [3];
  logic        signed_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy  [3];
  logic        done  [3];
  logic        ovf   [3];
  logic [31:0] prod  [3];

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  sm_multiplier_core #(.WIDTH(16), .STEP(1)) u_dut_s1 (
    .clock(clock), .reset_in(reset_in), .start_in(start[0]), .signed_in(signed_in),
    .multiplicand_in(a), .multiplier_in(b), .busy_out(busy[0]), .done_out(done[0]),
    .product_out(prod[0]), .overflow_out(ovf[0]));

  sm_multiplier_core #(.WIDTH(16), .STEP(2)) u_dut_s2 (
    .clock(clock), .reset_in(reset_in), .start_in(start[1]), .signed_in(signed_in),
    .multiplicand_in(a), .multiplier_in(b), .busy_out(busy[1]), .done_out(done[1]),
    .product_out(prod[1]), .overflow_out(ovf[1]));

  sm_multiplier_core #(.WIDTH(16), .STEP(4)) u_dut_s4 (
    .clock(clock), .reset_in(reset_in), .start_in(start[2]), .signed_in(signed_in),
    .multiplicand_in(a), .multiplier_in(b), .busy_out(busy[2]), .done_out(done[2]),
    .product_out(prod[2]), .overflow_out(ovf[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  // Reference: exact integer product, then range test of the true value.
  function automatic logic [32:0] ref_mul(input logic sgn, input logic [15:0] x,
                                          input logic [15:0] y);
    longint      p;
    logic [63:0] pu;
    bit          ov;
    if (sgn) begin
      p  = longint'($signed(x)) * longint'($signed(y));
      ov = (p > 32767) || (p < -32768);
    end else begin
      p  = longint'(x) * longint'(y);
      ov = (p > 65535);
    end
    pu = p;
    return {ov, pu[31:0]};
  endfunction

  task automatic do_op(input int k, input logic sgn, input logic [15:0] x,
                       input logic [15:0] y, input string tag);
    int          n;
    int          lat;
    bit          busy_ok;
    logic [32:0] r;
    n = 16 / step_of(k);
    r = ref_mul(sgn, x, y);
    @(negedge clock);
    start[k] = 1'b1; signed_in = sgn; a = x; b = y;
    @(posedge clock); #1;
    start[k] = 1'b0; a = 16'($urandom); b = 16'($urandom); signed_in = 1'($urandom);
    busy_ok = busy[k];
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done[k]) begin lat = i; break; end
      if (!busy[k]) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, lat, n + 1);
    chk({tag, "_product"}, prod[k], r[31:0]);
    chk({tag, "_overflow"}, ovf[k], r[32]);
    chk({tag, "_busy"}, {busy_ok, busy[k]}, 2'b10);
  endtask

  initial begin
    int lat;
    int dcount;
    int t1;
    int t2;
    reset_in = 1'b1; signed_in = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++)
      chk("reset_state", {busy[k], done[k], ovf[k], prod[k]}, '0);
    @(negedge clock);
    reset_in = 1'b0;

    do_op(0, 1'b0, 16'd300,   16'd200,   "u_s1_300x200");
    chk("u_s1_300x200_const", prod[0], 32'h0000_EA60);
    do_op(0, 1'b1, 16'hFFFD,  16'd7,     "s_s1_m3x7");
    chk("s_s1_m3x7_const", prod[0], 32'hFFFF_FFEB);
    do_op(0, 1'b1, 16'hFFFF,  16'd0,     "s_s1_m1x0");
    do_op(1, 1'b1, 16'h8000,  16'h8000,  "s_s2_min_x_min");
    chk("s_s2_min_x_min_const", {ovf[1], prod[1]}, {1'b1, 32'h4000_0000});
    do_op(1, 1'b1, 16'h8000,  16'h0001,  "s_s2_min_x_1");
    chk("s_s2_min_x_1_const", {ovf[1], prod[1]}, {1'b0, 32'hFFFF_8000});
    do_op(2, 1'b0, 16'hFFFF,  16'hFFFF,  "u_s4_max_x_max");
    chk("u_s4_max_x_max_const", {ovf[2], prod[2]}, {1'b1, 32'hFFFE_0001});
    do_op(2, 1'b1, 16'h7FFF,  16'h8000,  "s_s4_max_x_min");

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 12; i++)
        do_op(k, 1'($urandom), 16'($urandom), 16'($urandom), "random");

    // Start pulse mid-RUN must be ignored.
    @(negedge clock);
    start[0] = 1'b1; signed_in = 1'b0; a = 16'd9; b = 16'd9;
    @(posedge clock); #1;
    start[0] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (i == 4) begin start[0] = 1'b1; a = 16'd5; b = 16'd5; end
      if (i == 5) start[0] = 1'b0;
      if (done[0]) begin lat = i; break; end
    end
    start[0] = 1'b0;
    chk("ignore_start_latency", lat, 17);
    chk("ignore_start_product", prod[0], 32'd81);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done[0]) dcount++;
    end
    chk("ignore_start_no_second_done", dcount, 0);

    // Start held through the done cycle: back-to-back acceptance.
    @(negedge clock);
    start[0] = 1'b1; signed_in = 1'b0; a = 16'd300; b = 16'd200;
    @(posedge clock); #1;
    t1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done[0]) begin t1 = i; break; end
    end
    chk("b2b_first_latency", t1, 17);
    chk("b2b_first_product", prod[0], 32'h0000_EA60);
    a = 16'd77; b = 16'd3; signed_in = 1'b1;
    @(posedge clock); #1;
    start[0] = 1'b0;
    t2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done[0]) begin t2 = i + 1; break; end
    end
    chk("b2b_done_spacing", t2, 18);
    chk("b2b_second_result", {ovf[0], prod[0]}, {1'b0, 32'd231});

    // Asynchronous reset in the middle of RUN.
    @(negedge clock);
    start[0] = 1'b1; signed_in = 1'b0; a = 16'd1000; b = 16'd1000;
    @(posedge clock); #1;
    start[0] = 1'b0;
    repeat (7) @(posedge clock);
    #2 reset_in = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      chk("async_reset_outputs", {busy[k], done[k], ovf[k], prod[k]}, '0);
    @(negedge clock);
    reset_in = 1'b0;
    do_op(0, 1'b0, 16'd12, 16'd12, "after_reset_12x12");
    chk("after_reset_12x12_const", prod[0], 32'h0000_0090);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_multiplier_core.md
# sm_multiplier_core

Parametrised sequential multiplier that replaces the fixed 16-bit control-plus-datapath arrangement with one self-contained block. It computes a full 2·WIDTH product of two WIDTH-bit operands over a configurable number of cycles. Signed or unsigned mode is selected per operation. It sits on the multiplicators datapath as a start/busy/done coprocessor and holds its result until the next operation completes.

## Interface
- WIDTH, 16: operand width in bits; must be ≥ 2.
- STEP, 1: multiplier bits consumed per iteration; legal values 1, 2, 4, and WIDTH must be divisible by STEP.

- clock  in  1  system clock; all state updates on the rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- start_in  in  1  request; sampled on the rising edge only while the FSM is in IDLE.
- signed_in  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- multiplicand_in  in  WIDTH  operand A; captured with start.
- multiplier_in  in  WIDTH  operand B; captured with start.
- busy_out  out  1  high while an operation is in flight (state ≠ IDLE).
- done_out  out  1  one-cycle pulse; product_out and overflow_out are valid from this cycle on.
- product_out  out  2·WIDTH  full product, registered, held until the next done_out.
- overflow_out  out  1  product not representable in WIDTH bits for the captured mode; held with product_out.

## Operation
- FSM states (shared enum): IDLE, RUN, FIX.
- IDLE with start_in = 1:
  - Capture the operand magnitudes |A| and |B|. In unsigned mode these are the raw values. In signed mode, negate when the MSB is 1; |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned.
  - Capture neg = signed_in & (A[MSB] ^ B[MSB]).
  - Load acc_hi = 0 (WIDTH+STEP bits) and acc_lo = |B|.
  - Load iteration counter = WIDTH/STEP, then go to RUN.
- RUN, each cycle:
  - acc_hi ← acc_hi + |A|·acc_lo[STEP−1:0].
  - Shift {acc_hi, acc_lo} right by STEP.
  - Decrement the counter. When it reaches 0, go to FIX.
- FIX, one cycle:
  - mag = {acc_hi[WIDTH−1:0], acc_lo}.
  - product_out ← neg ? −mag : mag. Negating 0 yields 0, so there is no negative zero.
  - overflow_out ← unsigned mode: product[2W−1:W] ≠ 0. Signed mode: product[2W−1:W−1] is not all-0s and not all-1s.
  - Assert done_out, then go to IDLE.
- start_in while busy_out = 1 is ignored: no capture, no error, no effect on the in-flight operation.
- Operand inputs are don't-care except on the accepted start edge.
- Reset (any time, including mid-RUN/FIX):
  - FSM goes to IDLE; the in-flight result is discarded.
  - busy_out = 0, done_out = 0, product_out = 0, overflow_out = 0.
  - Internal accumulators and counter are cleared.

## Timing
- N = WIDTH/STEP.
- Edge 0: start accepted. busy_out is high from edge 0 until edge N+1.
- Edges 1..N: iterations. Edge N moves the FSM to FIX.
- Edge N+1: product_out, overflow_out and done_out update. done_out is high for exactly the cycle after edge N+1; busy_out is low in that cycle.
- Latency: N+1 cycles from the start edge to done_out (17 for 16/1, 5 for 16/4).
- Back-to-back: start_in high during the done_out cycle is accepted at the next edge, so throughput is one result per N+2 cycles.
- product_out keeps the old result until the new done_out.
- Reset deassertion: the first start can be accepted on the first rising edge after reset_in falls.

## Structure
- Package sm_pkg holds:
  - the typedef enum for states (IDLE/RUN/FIX);
  - a function returning the iteration count WIDTH/STEP;
  - an elaboration check constant that flags illegal STEP/WIDTH combinations (fatal at elaboration).
- Sub-module sm_partial_adder (combinational): inputs acc_hi, |A|, and a STEP-bit digit; output acc_hi + |A|·digit. It is instantiated once inside sm_multiplier_core.
- Everything else (operand conditioning, FSM, counter, sign fix, overflow) lives in sm_multiplier_core.

## Test plan
- Unsigned 16/1, 300 × 200 → product_out = 0x0000_EA60, overflow_out = 0, done_out 17 cycles after start, busy_out high for 17 cycles.
- Signed 16/1, −3 (0xFFFD) × 7 → product_out = 0xFFFF_FFEB, overflow_out = 0. Also −1 × 0 → 0x0000_0000.
- Signed 16/2, 0x8000 × 0x8000 → product_out = 0x4000_0000, overflow_out = 1. Also 0x8000 × 0x0001 → 0xFFFF_8000, overflow_out = 0.
- Unsigned 16/4, 0xFFFF × 0xFFFF → product_out = 0xFFFE_0001, overflow_out = 1, done_out 5 cycles after start.
- Handshake:
  - Pulse start_in (operands 5 × 5) mid-RUN of an ongoing 9 × 9 → result 81, no second done_out.
  - Start held high across the done_out cycle → second operation accepted, consecutive done_out pulses N+2 cycles apart.
- Reset mid-RUN (cycle 8 of 17) → all outputs 0 immediately (asynchronously). A following 12 × 12 unsigned → 0x0000_0090 with normal latency.
